// File: rtl/vga_define.sv
// Shared definitions for the VGA framebuffer fetch engine:
// FSM states, AXI4 burst constants and the 4 KB page size.
package vga_define;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ADDR,
      ST_DATA
   } state_e;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam int unsigned PAGE_BYTES    = 4096;

endpackage

// File: rtl/vga_burst_calc.sv
// Burst sizing: min(BURST_LEN, remaining words, words left in the
// current 4 KB page) so that no burst crosses a page boundary.
module vga_burst_calc
   import vga_define::*;
#(
   parameter int BURST_LEN = 16
) (
   input  logic [31:0] addr_i,
   input  logic [31:0] remain_i,
   output logic [8:0]  beats_o
);

   logic [31:0] page_left;
   logic [31:0] lim;
   logic        unused_sig;

   always_comb begin
      page_left = (32'(PAGE_BYTES) - {20'd0, addr_i[11:0]}) >> 2;
      lim = 32'(BURST_LEN);
      if (remain_i < lim) lim = remain_i;
      if (page_left < lim) lim = page_left;
   end

   assign beats_o    = lim[8:0];
   assign unused_sig = ^{addr_i[31:12], lim[31:9]};

endmodule

// File: rtl/vga_fb_fetch.sv
// VGA framebuffer fetch: walks the framebuffer in AXI4 INCR bursts.
// Define VGA_FETCH_ERR_EN to enable the sticky read-error flag err_o.
module vga_fb_fetch
   import vga_define::*;
#(
   parameter int BURST_LEN = 16,
   parameter int FIFO_AW   = 6
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               frame_start_i,
   input  logic [31:0]        fbstart_i,
   input  logic [31:0]        fbsize_i,
   input  logic [FIFO_AW:0]   fifo_free_i,
   output logic [31:0]        araddr_o,
   output logic [7:0]         arlen_o,
   output logic [2:0]         arsize_o,
   output logic [1:0]         arburst_o,
   output logic               arvalid_o,
   input  logic               arready_i,
   input  logic [31:0]        rdata_i,
   input  logic [1:0]         rresp_i,
   input  logic               rlast_i,
   input  logic               rvalid_i,
   output logic               rready_o,
   output logic               pix_wr_o,
   output logic [31:0]        pix_data_o,
   output logic               busy_o,
   output logic               err_o
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] remain_q, remain_d;
   logic [8:0]  beats_q, beats_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q, arlen_d;
   logic [2:0]  arsize_q, arsize_d;
   logic [1:0]  arburst_q, arburst_d;
   logic        arvalid_q, arvalid_d;

   logic [8:0]  beats_c;
   logic [8:0]  len_m1;
   logic        fifo_ok;
   logic        frame_acc;
   logic        unused_sig;

   vga_burst_calc #(
      .BURST_LEN (BURST_LEN)
   ) u_calc (
      .addr_i   (addr_q),
      .remain_i (remain_q),
      .beats_o  (beats_c)
   );

   assign len_m1    = beats_c - 9'd1;
   assign fifo_ok   = 32'(fifo_free_i) >= {23'd0, beats_c};
   assign frame_acc = (state_q == ST_IDLE) && frame_start_i
                      && en_i && (fbsize_i != 32'd0);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      beats_d   = beats_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      arvalid_d = arvalid_q;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_acc) begin
               addr_d   = fbstart_i;
               remain_d = fbsize_i;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!en_i) begin
               state_d = ST_IDLE;
            end else if (fifo_ok) begin
               araddr_d  = addr_q;
               arlen_d   = len_m1[7:0];
               arsize_d  = AXI_SIZE_4B;
               arburst_d = AXI_BURST_INCR;
               arvalid_d = 1'b1;
               beats_d   = beats_c;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (arready_i) begin
               arvalid_d = 1'b0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rvalid_i && rlast_i) begin
               addr_d   = addr_q + {21'd0, beats_q, 2'b00};
               remain_d = remain_q - {23'd0, beats_q};
               // a dropped enable is honoured only at a burst boundary
               if (remain_d == 32'd0 || !en_i) state_d = ST_IDLE;
               else state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         beats_q   <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         beats_q   <= beats_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         arvalid_q <= arvalid_d;
      end
   end

   assign araddr_o   = araddr_q;
   assign arlen_o    = arlen_q;
   assign arsize_o   = arsize_q;
   assign arburst_o  = arburst_q;
   assign arvalid_o  = arvalid_q;
   assign busy_o     = state_q != ST_IDLE;
   assign rready_o   = state_q == ST_DATA;
   assign pix_wr_o   = rready_o && rvalid_i;
   assign pix_data_o = pix_wr_o ? rdata_i : 32'd0;

`ifdef VGA_FETCH_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (frame_acc) err_d = 1'b0;
      if (pix_wr_o && rresp_i[1]) err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign unused_sig = ^{rresp_i, len_m1[8]};

endmodule

// File: doc/vga_fb_fetch.md
VGA_FB_FETCH -- requirements
Module: vga_fb_fetch

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, max AXI4 INCR beats per burst (power of two, 1..256).
REQ-002 SHALL have parameter FIFO_AW, default 6, log2 of the downstream pixel FIFO depth.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  sole clock, all state on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 en_i  in  1  fetch enable (VGA_CTRL enable bit).
REQ-007 frame_start_i  in  1  one-cycle pulse at start of vertical sync.
REQ-008 fbstart_i  in  32  framebuffer byte base address, 4-byte aligned.
REQ-009 fbsize_i  in  32  framebuffer size in 32-bit words.
REQ-010 fifo_free_i  in  FIFO_AW+1  free word slots in the pixel FIFO.
REQ-011 araddr_o/arlen_o/arsize_o/arburst_o  out  32/8/3/2  AXI4 read address payload.
REQ-012 arvalid_o  out  1 and arready_i  in  1  AXI4 AR handshake.
REQ-013 rdata_i  in  32, rresp_i  in  2, rlast_i  in  1, rvalid_i  in  1, rready_o  out  1  AXI4 R channel.
REQ-014 pix_wr_o  out  1 and pix_data_o  out  32  pixel FIFO write strobe and data.
REQ-015 busy_o  out  1  high whenever state is not IDLE.
REQ-016 err_o  out  1  sticky read-error flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, REQ, ADDR, DATA.
REQ-018 IDLE: frame_start_i && en_i && fbsize_i!=0 SHALL latch addr=fbstart_i, remain=fbsize_i, go to REQ next cycle; otherwise stay.
REQ-019 REQ: beats = min(BURST_LEN, remain, (4096-addr[11:0])/4); no burst SHALL cross a 4 KB boundary.
REQ-020 REQ: when fifo_free_i >= beats, SHALL register araddr_o=addr, arlen_o=beats-1, arsize_o=3'b010, arburst_o=2'b01, set arvalid_o, go to ADDR.
REQ-021 ADDR: arvalid_o and payload SHALL stay stable until arvalid_o && arready_i, then go to DATA with arvalid_o low.
REQ-022 DATA: rready_o=1; each rvalid_i cycle SHALL assert pix_wr_o with pix_data_o=rdata_i combinationally, zero added latency.
REQ-023 DATA on rvalid_i && rlast_i: addr += beats*4 (32-bit wrap), remain -= beats; remain==0 -> IDLE, else REQ.
REQ-024 At most one burst outstanding; pixel FIFO overflow is impossible by REQ-020.
REQ-025 frame_start_i outside IDLE SHALL be ignored; en_i deassert SHALL complete the in-flight burst (from ADDR or DATA) then go to IDLE; in REQ, SHALL go to IDLE immediately.
REQ-026 rready_o, pix_wr_o SHALL be 0 outside DATA; arvalid_o 0 outside ADDR.

Reset
REQ-027 rst_i SHALL force IDLE, addr=0, remain=0, beats=0, and all outputs 0 the following cycle, including mid-burst.

Configuration
REQ-028 Macro VGA_FETCH_ERR_EN defined: err_o SHALL set the cycle after rvalid_i && rresp_i[1], hold until the next accepted frame start (REQ-018) or reset; fetch continues regardless.
REQ-029 Macro undefined: err_o SHALL be constant 0, rresp_i unused.

Structure
REQ-030 State encoding, AXI constants (size 3'b010, INCR 2'b01) and 4 KB page size SHALL live in shared vga_define.sv.
REQ-031 Burst-length computation SHALL be one combinational sub-module vga_burst_calc (addr, remain -> beats).

Verification
REQ-032 fbstart=0x8000_0000, fbsize=40, free=64 -> AR: 0x8000_0000 len15, 0x8000_0040 len15, 0x8000_0080 len7; 40 pix_wr; then IDLE.
REQ-033 fbstart=0x0000_0FF0, fbsize=16 -> AR 0x0FF0 len3, then 0x1000 len11.
REQ-034 remain=32, free=10 -> arvalid_o stays 0; free raised to 16 -> arvalid_o=1 next cycle, arlen=15.
REQ-035 arready_i low 5 cycles -> arvalid_o=1, araddr/arlen unchanged throughout; handshake on cycle 6.
REQ-036 rst_i during DATA beat 3 -> next cycle busy_o=0, rready_o=0, pix_wr_o=0; new frame_start restarts at fbstart.
REQ-037 With VGA_FETCH_ERR_EN, rresp=2'b10 on beat 2 -> err_o=1 next cycle, fetch completes, err_o=0 after next accepted frame_start.
